// File: rtl/score_bcd_disp.sv
// score_bcd_disp: binary-to-BCD converter feeding a serial 7-segment driver, with rate-limited refresh pulses
module score_bcd_disp #(
  parameter int BIN_W          = 27,
  parameter int REFRESH_CYCLES = 1024,
  parameter int MIN_GAP        = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_valid,
  output logic             bin_ready,
  output logic [31:0]      num,
  output logic             start,
  output logic             overflow
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int SW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t           state;
  logic [BIN_W-1:0] sh;
  logic [31:0]      bcd, adj, nxt;
  logic [SW-1:0]    step;
  logic [CW-1:0]    cnt;
  logic             sat, pending, last;
  for (genvar g = 0; g < 8; g++) begin : g_adj
    assign adj[4*g+:4] = bcd[4*g+:4] >= 4'd5 ? bcd[4*g+:4] + 4'd3 : bcd[4*g+:4];
  end
  assign nxt       = {adj[30:0], sh[BIN_W-1]};
  assign last      = state == CONV && step == SW'(BIN_W - 1);
  assign bin_ready = state == IDLE && !rst;
  // Deferred refreshes wait out MIN_GAP so the driver's shift always completes.
  assign start     = !rst && (cnt == CW'(REFRESH_CYCLES - 1) || (pending && cnt >= CW'(MIN_GAP)));
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      num      <= '0;
      overflow <= 1'b0;
      pending  <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      bcd      <= '0;
      step     <= '0;
      sat      <= 1'b0;
    end else begin
      cnt     <= start ? '0 : cnt + CW'(1);
      pending <= last || (pending && !start);
      if (state == IDLE) begin
        if (bin_valid) begin
          sh    <= bin_in;
          bcd   <= '0;
          sat   <= 32'(bin_in) > 32'd99_999_999;
          step  <= '0;
          state <= CONV;
        end
      end else begin
        sh   <= sh << 1;
        bcd  <= nxt;
        step <= step + SW'(1);
        if (last) begin
          num      <= sat ? 32'h9999_9999 : nxt;
          overflow <= sat;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_score_bcd_disp.sv
// tb_score_bcd_disp: randomized self-checking bench against a digit-arithmetic reference model
module tb_score_bcd_disp;
  logic        clk = 0, rst = 1, bin_valid = 0;
  logic [26:0] bin_in = '0;
  logic        bin_ready, start, overflow;
  logic [31:0] num;
  int n_chk = 0, n_pass = 0;
  int since = 0, busy = 0, left = 0, latched = 0, cyc = 0, last_start = 0;
  bit pend = 0, m_start = 0, seen_start = 0, acc = 0, chk_en = 0;
  logic [31:0] exp_num = '0;
  logic        exp_ovf = 0;

  score_bcd_disp dut (.clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .num(num), .start(start), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] r = '0;
    int p = 1;
    if (v > 99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  task automatic tick();
    bit upd = 0;
    @(posedge clk);
    cyc++;
    acc = 0;
    if (rst) begin
      since = 0; pend = 0; busy = 0; exp_num = '0; exp_ovf = 0; seen_start = 0;
    end else begin
      if (busy != 0) begin
        left--;
        if (left == 0) begin
          busy = 0; upd = 1;
          exp_num = to_bcd(latched);
          exp_ovf = latched > 99_999_999;
        end
      end else if (bin_valid) begin
        busy = 1; left = 27; latched = int'(bin_in); acc = 1;
      end
      if (m_start) begin since = 0; pend = 0; end
      else since++;
      if (upd) pend = 1;
    end
    #1;
    m_start = !rst && (since == 1023 || (pend && since >= 96));
    if (chk_en) begin
      check("start", start, m_start);
      check("num", num, exp_num);
      check("overflow", overflow, exp_ovf);
      check("bin_ready", bin_ready, !rst && busy == 0);
      if (start) begin
        if (seen_start) check("gap>=97", (cyc - last_start) >= 97, 1);
        seen_start = 1; last_start = cyc;
      end
    end
  endtask

  task automatic send(int v);
    int n = 0;
    bin_in = 27'(v);
    bin_valid = 1;
    do begin tick(); n++; end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    bin_valid = 0;
  endtask

  task automatic wait_since(int s);
    int n = 0;
    while (since != s && n < 3000) begin tick(); n++; end
    if (since != s) check("wait_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  initial begin
    tick();
    chk_en = 1;
    do_reset();
    send(12_345_678);
    repeat (30) tick();
    send(0);
    repeat (30) tick();
    send(99_999_999);
    repeat (30) tick();
    send(100_000_000);
    repeat (30) tick();
    send(42);
    repeat (30) tick();
    do_reset();
    repeat (5000) tick();
    wait_since(1007);
    send(7);
    repeat (150) tick();
    wait_since(473);
    send(7);
    repeat (150) tick();
    send(5_555_555);
    repeat (13) tick();
    rst = 1;
    tick();
    rst = 0;
    tick();
    send(5_555_555);
    repeat (30) tick();
    for (int i = 0; i < 30; i++) begin
      int sel = int'($urandom_range(0, 3));
      int v = sel == 0 ? int'($urandom_range(0, 999)) :
              sel == 1 ? int'($urandom_range(99_999_990, 100_000_010)) :
              int'($urandom & 32'h07ff_ffff);
      send(v);
      repeat ($urandom_range(0, 40)) tick();
    end
    repeat (40) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
